// File: rtl/hv_proj_mem_server_pkg.sv
// Shared constants and types for the HV projection memory server.
// Holds the hypervector/bank geometry, bank-select codes and the FSM state type.
package hv_proj_mem_server_pkg;

    function automatic int unsigned ceil_log2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return (r == 0) ? 1 : r;
    endfunction

    localparam int unsigned HV_DIM = 2000;
    localparam int unsigned DEPTH  = 214;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned CHUNKS = (HV_DIM + WORD_W - 1) / WORD_W;
    localparam int unsigned ADDR_W = ceil_log2(DEPTH);
    localparam int unsigned CNT_W  = ceil_log2(CHUNKS);
    localparam int unsigned WSEL_W = ceil_log2(WORD_W);

    localparam logic [1:0] BANK_IM  = 2'd0;
    localparam logic [1:0] BANK_NEG = 2'd1;
    localparam logic [1:0] BANK_POS = 2'd2;

    typedef logic [HV_DIM-1:0] hv_t;
    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StWrite,
        StServe
    } state_e;

endpackage

// File: rtl/hv_proj_mem_server_if.sv
// Bus bundle between the memory server and its host (row loader) and encoder.
// slave  : the server side (drives LoadReady/Sram*/data/LoadErr).
// master : the host + encoder side (drives Load*, Flush, Spatial*, SramAddr).
interface hv_proj_mem_server_if;
    import hv_proj_mem_server_pkg::*;

    logic              LoadValid_SI;
    logic              LoadReady_SO;
    logic [1:0]        LoadBank_DI;
    addr_t             LoadAddr_DI;
    logic [WORD_W-1:0] LoadData_DI;
    logic              LoadDone_SI;
    logic              Flush_SI;
    logic              SpatialReady_SI;
    logic              SpatialValid_SI;
    addr_t             SramAddr_DI;
    logic              SramReady_SO;
    logic [2:0]        SramValid_SO;
    hv_t               IMOut_DO;
    hv_t               ProjNeg_DO;
    hv_t               ProjPos_DO;
    logic              LoadErr_SO;

    modport slave (
        input  LoadValid_SI, LoadBank_DI, LoadAddr_DI, LoadData_DI, LoadDone_SI, Flush_SI,
               SpatialReady_SI, SpatialValid_SI, SramAddr_DI,
        output LoadReady_SO, SramReady_SO, SramValid_SO, IMOut_DO, ProjNeg_DO, ProjPos_DO,
               LoadErr_SO
    );

    modport master (
        output LoadValid_SI, LoadBank_DI, LoadAddr_DI, LoadData_DI, LoadDone_SI, Flush_SI,
               SpatialReady_SI, SpatialValid_SI, SramAddr_DI,
        input  LoadReady_SO, SramReady_SO, SramValid_SO, IMOut_DO, ProjNeg_DO, ProjPos_DO,
               LoadErr_SO
    );
endinterface

// File: rtl/hv_proj_mem_server_row_ram.sv
// 1R1W synchronous row RAM, HV_DIM x DEPTH, one-cycle registered read.
// Ports: Clk_CI, Reset_RI (clears only the read register, never the array),
//        WrEn_SI/WrAddr_DI/WrData_DI write port, RdEn_SI/RdAddr_DI read port,
//        RdData_DO registered read data (held while RdEn_SI is low).
module hv_proj_mem_server_row_ram
    import hv_proj_mem_server_pkg::*;
(
    input  logic  Clk_CI,
    input  logic  Reset_RI,
    input  logic  WrEn_SI,
    input  addr_t WrAddr_DI,
    input  hv_t   WrData_DI,
    input  logic  RdEn_SI,
    input  addr_t RdAddr_DI,
    output hv_t   RdData_DO
);
    hv_t mem_q [DEPTH];
    hv_t rd_data_q;

    always_ff @(posedge Clk_CI) begin
        if (WrEn_SI) begin
            mem_q[WrAddr_DI] <= WrData_DI;
        end
    end

    always_ff @(posedge Clk_CI) begin
        if (Reset_RI) begin
            rd_data_q <= '0;
        end else if (RdEn_SI) begin
            rd_data_q <= mem_q[RdAddr_DI];
        end
    end

    assign RdData_DO = rd_data_q;
endmodule

// File: rtl/hv_proj_mem_server.sv
// Memory-side responder for the spatial encoder's SRAM read interface.
// Rows of three banks (IM, projM_neg, projM_pos) are loaded by a host as WORD_W chunks,
// then served one row per address with a tag/prefetch scheme that sustains one row per cycle.
// Ports: Clk_CI, Reset_RI (synchronous, active-high), bus (slave modport: load stream,
//        load-done/flush controls, encoder request/address, row outputs, sticky LoadErr_SO).
module hv_proj_mem_server
    import hv_proj_mem_server_pkg::*;
(
    input logic                 Clk_CI,
    input logic                 Reset_RI,
    hv_proj_mem_server_if.slave bus
);
    state_e           state_q, state_d;
    logic [CNT_W-1:0] chunk_q, chunk_d;
    hv_t              row_q, row_d;
    logic [1:0]       bank_q, bank_d;
    addr_t            addr_q, addr_d;
    logic             err_q, err_d;
    addr_t            tag_q, tag_d;
    logic             tag_valid_q, tag_valid_d;

    logic  load_fire, last_chunk, write_ok, wr_en;
    logic  req_in_range, hit, rd_en;
    addr_t next_addr, rd_addr;

    assign load_fire  = bus.LoadValid_SI & bus.LoadReady_SO;
    assign last_chunk = (chunk_q == CNT_W'(CHUNKS - 1));
    // Width-extended compares so DEPTH == 2**ADDR_W would still work.
    assign write_ok   = (bank_q != 2'd3) && ({1'b0, addr_q} < (ADDR_W + 1)'(DEPTH));
    assign wr_en      = (state_q == StWrite) && write_ok && !Reset_RI;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge Clk_CI) begin
        if (Reset_RI) state_q <= StIdle;
        else          state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (load_fire)            state_d = StLoad;
                else if (bus.LoadDone_SI) state_d = StServe;
            end
            StLoad:  if (load_fire && last_chunk) state_d = StWrite;
            StWrite: state_d = StIdle;
            StServe: if (bus.Flush_SI) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus.LoadReady_SO = 1'b0;
        bus.SramReady_SO = 1'b0;
        unique case (state_q)
            StIdle, StLoad: bus.LoadReady_SO = 1'b1;
            StServe:        bus.SramReady_SO = 1'b1;
            default:        ;
        endcase
    end

    // ---------------- Chunk assembly and error flag ----------------
    always_comb begin
        chunk_d = chunk_q;
        row_d   = row_q;
        bank_d  = bank_q;
        addr_d  = addr_q;
        err_d   = err_q;
        if (load_fire) begin
            // Bits past HV_DIM in the final chunk have no slot and are dropped.
            for (int unsigned i = 0; i < HV_DIM; i++) begin
                if (CNT_W'(i / WORD_W) == chunk_q) begin
                    row_d[i] = bus.LoadData_DI[WSEL_W'(i % WORD_W)];
                end
            end
            chunk_d = last_chunk ? '0 : chunk_q + CNT_W'(1);
            if (state_q == StIdle) begin
                bank_d = bus.LoadBank_DI;
                addr_d = bus.LoadAddr_DI;
            end
        end
        if ((state_q == StWrite) && !write_ok)      err_d = 1'b1;
        if ((state_q == StServe) && bus.Flush_SI)   err_d = 1'b0;
    end

    // ---------------- Read path: tag + prefetch ----------------
    assign req_in_range = {1'b0, bus.SramAddr_DI} < (ADDR_W + 1)'(DEPTH);
    assign hit = (state_q == StServe) && tag_valid_q && (tag_q == bus.SramAddr_DI) &&
                 req_in_range && bus.SpatialReady_SI;
    assign next_addr = (bus.SramAddr_DI == ADDR_W'(DEPTH - 1)) ? '0
                                                                : bus.SramAddr_DI + ADDR_W'(1);
    // Fetch the next row when the encoder consumes this one; otherwise re-read the requested row.
    assign rd_addr = (hit && bus.SpatialValid_SI) ? next_addr : bus.SramAddr_DI;
    assign rd_en   = (state_q == StServe) && !bus.Flush_SI && req_in_range;

    always_comb begin
        tag_d       = rd_en ? rd_addr : tag_q;
        tag_valid_d = rd_en;
    end

    assign bus.SramValid_SO = {3{hit}};
    assign bus.LoadErr_SO   = err_q;

    always_ff @(posedge Clk_CI) begin
        if (Reset_RI) begin
            chunk_q     <= '0;
            bank_q      <= '0;
            addr_q      <= '0;
            err_q       <= 1'b0;
            tag_q       <= '0;
            tag_valid_q <= 1'b0;
        end else begin
            chunk_q     <= chunk_d;
            bank_q      <= bank_d;
            addr_q      <= addr_d;
            err_q       <= err_d;
            tag_q       <= tag_d;
            tag_valid_q <= tag_valid_d;
        end
    end

    // Assembly register needs no reset: every chunk is rewritten before a row is committed.
    always_ff @(posedge Clk_CI) begin
        if (!Reset_RI) row_q <= row_d;
    end

    // ---------------- Banks ----------------
    hv_proj_mem_server_row_ram u_ram_im (
        .Clk_CI    (Clk_CI),
        .Reset_RI  (Reset_RI),
        .WrEn_SI   (wr_en && (bank_q == BANK_IM)),
        .WrAddr_DI (addr_q),
        .WrData_DI (row_q),
        .RdEn_SI   (rd_en),
        .RdAddr_DI (rd_addr),
        .RdData_DO (bus.IMOut_DO)
    );

    hv_proj_mem_server_row_ram u_ram_neg (
        .Clk_CI    (Clk_CI),
        .Reset_RI  (Reset_RI),
        .WrEn_SI   (wr_en && (bank_q == BANK_NEG)),
        .WrAddr_DI (addr_q),
        .WrData_DI (row_q),
        .RdEn_SI   (rd_en),
        .RdAddr_DI (rd_addr),
        .RdData_DO (bus.ProjNeg_DO)
    );

    hv_proj_mem_server_row_ram u_ram_pos (
        .Clk_CI    (Clk_CI),
        .Reset_RI  (Reset_RI),
        .WrEn_SI   (wr_en && (bank_q == BANK_POS)),
        .WrAddr_DI (addr_q),
        .WrData_DI (row_q),
        .RdEn_SI   (rd_en),
        .RdAddr_DI (rd_addr),
        .RdData_DO (bus.ProjPos_DO)
    );
endmodule

// File: tb/tb_hv_proj_mem_server.sv
// Directed bench for hv_proj_mem_server: loads rows, serves them through the tag/prefetch
// read path, and checks row data via a scoreboard of expected row addresses.
module tb_hv_proj_mem_server;
    import hv_proj_mem_server_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hv_proj_mem_server_if bus ();

    hv_proj_mem_server dut (
        .Clk_CI   (clk),
        .Reset_RI (rst),
        .bus      (bus)
    );

    int total = 0;
    int bad   = 0;
    int unsigned sb_q[$];

    function automatic logic [31:0] chunk_of(input int unsigned v, input int unsigned k);
        return (v * 32'h9E37_79B1) ^ (k * 32'h85EB_CA6B) ^ 32'h5A5A_0000;
    endfunction

    function automatic hv_t row_of(input int unsigned v);
        hv_t r;
        logic [31:0] c;
        r = '0;
        for (int unsigned k = 0; k < CHUNKS; k++) begin
            c = chunk_of(v, k);
            for (int unsigned j = 0; j < WORD_W; j++) begin
                if (k * WORD_W + j < HV_DIM) r[k * WORD_W + j] = c[j];
            end
        end
        return r;
    endfunction

    task automatic chk1(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_row(input string tag, input hv_t obs, input hv_t exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed[63:0]=%h expected[63:0]=%h", tag, obs[63:0], exp[63:0]);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Later chunks carry a scrambled address: only the first chunk's address may count.
    task automatic load_row(input logic [1:0] bank, input int unsigned addr,
                            input int unsigned v, input int unsigned n);
        for (int unsigned k = 0; k < n; k++) begin
            bus.LoadValid_SI = 1'b1;
            bus.LoadBank_DI  = bank;
            bus.LoadAddr_DI  = (k == 0) ? ADDR_W'(addr) : ADDR_W'(addr ^ 32'h55);
            bus.LoadData_DI  = chunk_of(v, k);
            @(negedge clk);
            if (k == 0 || k == n - 1) chk1("load_ready", 32'(bus.LoadReady_SO), 1);
            next_cycle();
        end
        bus.LoadValid_SI = 1'b0;
        if (n == CHUNKS) begin
            @(negedge clk);
            chk1("write_ready_low", 32'(bus.LoadReady_SO), 0);
            next_cycle();
        end
    endtask

    task automatic load_all(input int unsigned addr);
        for (int unsigned b = 0; b < 3; b++) load_row(2'(b), addr, addr * 3 + b, CHUNKS);
    endtask

    task automatic srv(input int unsigned addr, input logic rdy, input logic sv,
                       input logic exp_v, input logic chk_data, input string tag);
        int unsigned a;
        bus.SpatialReady_SI = rdy;
        bus.SpatialValid_SI = sv;
        bus.SramAddr_DI     = ADDR_W'(addr);
        if (chk_data) sb_q.push_back(addr);
        @(negedge clk);
        chk1({tag, "_sram_ready"}, 32'(bus.SramReady_SO), 1);
        chk1({tag, "_valid"}, 32'(bus.SramValid_SO), 32'({3{exp_v}}));
        if (bus.SramValid_SO === 3'b111 && sb_q.size() > 0) begin
            a = sb_q.pop_front();
            chk_row({tag, "_im"},  bus.IMOut_DO,   row_of(a * 3 + 0));
            chk_row({tag, "_neg"}, bus.ProjNeg_DO, row_of(a * 3 + 1));
            chk_row({tag, "_pos"}, bus.ProjPos_DO, row_of(a * 3 + 2));
        end
        next_cycle();
    endtask

    task automatic flush_check();
        bus.Flush_SI = 1'b1;
        @(negedge clk);
        chk1("flush_cycle_ready", 32'(bus.SramReady_SO), 1);
        next_cycle();
        bus.Flush_SI        = 1'b0;
        bus.SpatialReady_SI = 1'b0;
        @(negedge clk);
        chk1("flush_sram_ready", 32'(bus.SramReady_SO), 0);
        chk1("flush_valid", 32'(bus.SramValid_SO), 0);
        chk1("flush_load_ready", 32'(bus.LoadReady_SO), 1);
        chk1("flush_err", 32'(bus.LoadErr_SO), 0);
        next_cycle();
    endtask

    task automatic enter_serve(input int unsigned addr);
        bus.SpatialReady_SI = 1'b1;
        bus.SpatialValid_SI = 1'b1;
        bus.SramAddr_DI     = ADDR_W'(addr);
        bus.LoadDone_SI     = 1'b1;
        @(negedge clk);
        chk1("idle_sram_ready", 32'(bus.SramReady_SO), 0);
        chk1("idle_valid", 32'(bus.SramValid_SO), 0);
        next_cycle();
        bus.LoadDone_SI = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk1({tag, "_load_ready"}, 32'(bus.LoadReady_SO), 1);
        chk1({tag, "_sram_ready"}, 32'(bus.SramReady_SO), 0);
        chk1({tag, "_valid"}, 32'(bus.SramValid_SO), 0);
        chk1({tag, "_err"}, 32'(bus.LoadErr_SO), 0);
        chk_row({tag, "_im"},  bus.IMOut_DO,   '0);
        chk_row({tag, "_neg"}, bus.ProjNeg_DO, '0);
        chk_row({tag, "_pos"}, bus.ProjPos_DO, '0);
    endtask

    initial begin
        rst                 = 1'b1;
        bus.LoadValid_SI    = 1'b0;
        bus.LoadBank_DI     = '0;
        bus.LoadAddr_DI     = '0;
        bus.LoadData_DI     = '0;
        bus.LoadDone_SI     = 1'b0;
        bus.Flush_SI        = 1'b0;
        bus.SpatialReady_SI = 1'b0;
        bus.SpatialValid_SI = 1'b0;
        bus.SramAddr_DI     = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        next_cycle();

        // Test 1: load rows, enter SERVE, stream rows 0..3.
        load_all(0); load_all(1); load_all(2); load_all(3);
        load_all(4); load_all(5); load_all(212); load_all(213);
        @(negedge clk);
        chk1("err_after_good_loads", 32'(bus.LoadErr_SO), 0);
        next_cycle();
        enter_serve(0);
        srv(0, 1, 1, 0, 0, "t1_bubble");
        srv(0, 1, 1, 1, 1, "t1_row0");
        srv(1, 1, 1, 1, 1, "t1_row1");
        srv(2, 1, 1, 1, 1, "t1_row2");
        srv(3, 1, 1, 1, 1, "t1_row3");
        // Test 2: stall on row 5.
        srv(4, 1, 1, 1, 1, "t2_row4");
        for (int i = 0; i < 4; i++) srv(5, 1, 0, 1, 1, "t2_hold5");
        // Test 3: wrap 213 -> 0 with no bubble.
        srv(212, 1, 1, 0, 0, "t3_miss");
        srv(212, 1, 1, 1, 1, "t3_row212");
        srv(213, 1, 1, 1, 1, "t3_row213");
        srv(0,   1, 1, 1, 1, "t3_wrap0");
        // Test 4: jump from 40 back to 0.
        srv(38, 1, 1, 0, 0, "t4_miss");
        srv(38, 1, 1, 1, 0, "t4_a38");
        srv(39, 1, 1, 1, 0, "t4_a39");
        srv(40, 1, 1, 1, 0, "t4_a40");
        srv(0,  1, 1, 0, 0, "t4_jump_bubble");
        srv(0,  1, 1, 1, 1, "t4_row0");
        // Out of range, not ready, and held-after-prefetch mispredict.
        srv(220, 1, 1, 0, 0, "oor_a");
        srv(220, 1, 0, 0, 0, "oor_b");
        srv(1, 0, 1, 0, 0, "not_ready");
        srv(1, 1, 0, 1, 1, "ready_again");
        srv(1, 1, 1, 1, 1, "prefetch2");
        srv(1, 1, 0, 0, 0, "hold_mispredict");
        srv(1, 1, 0, 1, 1, "hold_recover");
        flush_check();

        // Test 5: reset in the middle of a row load.
        load_row(BANK_IM, 6, 99, 30);
        bus.LoadValid_SI = 1'b1;
        bus.LoadData_DI  = chunk_of(99, 30);
        rst              = 1'b1;
        next_cycle();
        rst              = 1'b0;
        bus.LoadValid_SI = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid_load_reset");
        next_cycle();
        load_all(6);

        // Test 6: bad address and bad bank.
        load_row(BANK_IM, 214, 500, CHUNKS);
        @(negedge clk);
        chk1("err_bad_addr", 32'(bus.LoadErr_SO), 1);
        next_cycle();
        load_row(2'd3, 1, 501, CHUNKS);
        @(negedge clk);
        chk1("err_sticky_bad_bank", 32'(bus.LoadErr_SO), 1);
        next_cycle();
        enter_serve(1);
        srv(1, 1, 0, 0, 0, "t6_bubble");
        srv(1, 1, 0, 1, 1, "t6_row1_intact");
        srv(3, 1, 0, 0, 0, "t5_miss3");
        srv(3, 1, 0, 1, 1, "t5_row3_intact");
        srv(6, 1, 0, 0, 0, "t5_miss6");
        srv(6, 1, 0, 1, 1, "t5_row6_fresh");
        @(negedge clk);
        chk1("err_sticky_serve", 32'(bus.LoadErr_SO), 1);
        next_cycle();
        flush_check();

        chk1("scoreboard_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
